// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - board geometry, colour type, controller states and line score table
package tetris_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int COLOUR_W = 3;
    localparam int XW       = $clog2(BOARD_W);
    localparam int YW       = $clog2(BOARD_H);

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} lcc_state_t;

    // Points awarded for clearing 0..4 lines in one lock-in
    function automatic logic [23:0] line_score(input logic [2:0] lines);
        case (lines)
            3'd1:    return 24'd40;
            3'd2:    return 24'd100;
            3'd3:    return 24'd300;
            3'd4:    return 24'd1200;
            default: return 24'd0;
        endcase
    endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - piece lock-in, full-line scan and row shift sequencer (score via LINE_CLEAR_SCORE_EN)
module line_clear_ctrl
    import tetris_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          validate_start,
    input  logic [5:0]    x0,
    input  logic [5:0]    x1,
    input  logic [5:0]    x2,
    input  logic [5:0]    x3,
    input  logic [5:0]    y0,
    input  logic [5:0]    y1,
    input  logic [5:0]    y2,
    input  logic [5:0]    y3,
    input  colour_t       write_colour,
    output logic [XW-1:0] mem_rd_x,
    output logic [YW-1:0] mem_rd_y,
    input  logic          mem_rd_occ,
    input  colour_t       mem_rd_colour,
    output logic          mem_we,
    output logic [XW-1:0] mem_wr_x,
    output logic [YW-1:0] mem_wr_y,
    output logic          mem_wr_occ,
    output colour_t       mem_wr_colour,
    output logic          busy,
    output logic          write_done,
    output logic          validate_done,
    output logic [2:0]    lines_cleared,
    output logic [23:0]   score
);

    localparam logic [XW-1:0] C_LAST = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] R_LAST = YW'(BOARD_H - 1);
    localparam logic [5:0]    W6     = 6'(BOARD_W);
    localparam logic [5:0]    H6     = 6'(BOARD_H);

    lcc_state_t      state;
    logic [3:0][5:0] px;
    logic [3:0][5:0] py;
    colour_t         pcol;
    logic [1:0]      k;
    logic [XW-1:0]   c;
    logic [YW-1:0]   r;
    logic [YW-1:0]   s;

    logic [5:0] cur_x;
    logic [5:0] cur_y;
    logic       cur_ok;

    assign cur_x  = px[k];
    assign cur_y  = py[k];
    assign cur_ok = (cur_x < W6) && (cur_y < H6);

    assign busy          = (state != IDLE);
    assign validate_done = (state == DONE);

    // Memory port decode: piece writes, scan reads, and the read-then-write-below row copy
    always_comb begin
        mem_rd_x      = '0;
        mem_rd_y      = '0;
        mem_we        = 1'b0;
        mem_wr_x      = '0;
        mem_wr_y      = '0;
        mem_wr_occ    = 1'b0;
        mem_wr_colour = '0;
        case (state)
            WRITE: begin
                if (cur_ok) begin
                    mem_we        = 1'b1;
                    mem_wr_x      = cur_x[XW-1:0];
                    mem_wr_y      = cur_y[YW-1:0];
                    mem_wr_occ    = 1'b1;
                    mem_wr_colour = pcol;
                end
            end
            SCAN: begin
                mem_rd_x = c;
                mem_rd_y = r;
            end
            SHIFT: begin
                mem_we   = 1'b1;
                mem_wr_x = c;
                mem_wr_y = s;
                // Row 0 has nothing above it, so it is filled with empty cells
                if (s != '0) begin
                    mem_rd_x      = c;
                    mem_rd_y      = s - YW'(1);
                    mem_wr_occ    = mem_rd_occ;
                    mem_wr_colour = mem_rd_colour;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: latch piece, write 4 cells, scan rows bottom-up, shift down on each full row
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            px            <= '0;
            py            <= '0;
            pcol          <= '0;
            k             <= '0;
            c             <= '0;
            r             <= '0;
            s             <= '0;
            lines_cleared <= '0;
            write_done    <= 1'b0;
        end else begin
            write_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (validate_start) begin
                        px            <= {x3, x2, x1, x0};
                        py            <= {y3, y2, y1, y0};
                        pcol          <= write_colour;
                        lines_cleared <= '0;
                        r             <= R_LAST;
                        k             <= '0;
                        c             <= '0;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        write_done <= 1'b1;
                        c          <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!mem_rd_occ) begin
                        c <= '0;
                        if (r == '0) state <= DONE;
                        else         r     <= r - YW'(1);
                    end else if (c == C_LAST) begin
                        c     <= '0;
                        s     <= r;
                        state <= SHIFT;
                        if (lines_cleared != 3'd4) lines_cleared <= lines_cleared + 3'd1;
                    end else begin
                        c <= c + XW'(1);
                    end
                end
                SHIFT: begin
                    if (c == C_LAST) begin
                        c <= '0;
                        // After row 0 is blanked, rescan the same row: it now holds the row from above
                        if (s == '0) state <= SCAN;
                        else         s     <= s - YW'(1);
                    end else begin
                        c <= c + XW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic        to_done;
    logic [24:0] score_sum;

    assign to_done   = (state == SCAN) && !mem_rd_occ && (r == '0);
    assign score_sum = {1'b0, score} + {1'b0, line_score(lines_cleared)};

    // Score accumulates on entry to DONE so it is already updated while validate_done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else if (to_done) begin
            score <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - self-checking bench for line_clear_ctrl with board memory and compaction model
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    localparam int BUDGET = 4 + BOARD_H * BOARD_W * 5 + 50;
    localparam int SCORE_TBL [5] = '{0, 40, 100, 300, 1200};

    logic          clk = 1'b0;
    logic          rst;
    logic          validate_start;
    logic [5:0]    x0, x1, x2, x3, y0, y1, y2, y3;
    colour_t       write_colour;
    logic [XW-1:0] mem_rd_x;
    logic [YW-1:0] mem_rd_y;
    logic          mem_rd_occ;
    colour_t       mem_rd_colour;
    logic          mem_we;
    logic [XW-1:0] mem_wr_x;
    logic [YW-1:0] mem_wr_y;
    logic          mem_wr_occ;
    colour_t       mem_wr_colour;
    logic          busy, write_done, validate_done;
    logic [2:0]    lines_cleared;
    logic [23:0]   score;

    line_clear_ctrl dut (
        .clk(clk), .rst(rst), .validate_start(validate_start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .write_colour(write_colour),
        .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y), .mem_rd_occ(mem_rd_occ), .mem_rd_colour(mem_rd_colour),
        .mem_we(mem_we), .mem_wr_x(mem_wr_x), .mem_wr_y(mem_wr_y), .mem_wr_occ(mem_wr_occ),
        .mem_wr_colour(mem_wr_colour),
        .busy(busy), .write_done(write_done), .validate_done(validate_done),
        .lines_cleared(lines_cleared), .score(score)
    );

    always #5 clk = ~clk;

    // Board memory: combinational read, write at posedge; bulk load from preset arrays
    logic    b_occ [BOARD_H][BOARD_W];
    colour_t b_col [BOARD_H][BOARD_W];
    logic    p_occ [BOARD_H][BOARD_W];
    colour_t p_col [BOARD_H][BOARD_W];
    logic    load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int r = 0; r < BOARD_H; r++)
                for (int c = 0; c < BOARD_W; c++) begin
                    b_occ[r][c] <= p_occ[r][c];
                    b_col[r][c] <= p_col[r][c];
                end
        end else if (mem_we && int'(mem_wr_y) < BOARD_H && int'(mem_wr_x) < BOARD_W) begin
            b_occ[mem_wr_y][mem_wr_x] <= mem_wr_occ;
            b_col[mem_wr_y][mem_wr_x] <= mem_wr_colour;
        end
    end

    assign mem_rd_occ    = (int'(mem_rd_y) < BOARD_H && int'(mem_rd_x) < BOARD_W) ? b_occ[mem_rd_y][mem_rd_x] : 1'b0;
    assign mem_rd_colour = (int'(mem_rd_y) < BOARD_H && int'(mem_rd_x) < BOARD_W) ? b_col[mem_rd_y][mem_rd_x] : '0;

    // Reference model board
    logic    m_occ [BOARD_H][BOARD_W];
    colour_t m_col [BOARD_H][BOARD_W];
    int      hole  [BOARD_H];
    int      exp_score = 0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Remove every full row, let the rest fall, fill the top with empty rows
    task automatic model_compact(output int nfull);
        logic    t_occ [BOARD_H][BOARD_W];
        colour_t t_col [BOARD_H][BOARD_W];
        int dst;
        bit full;
        dst = BOARD_H - 1;
        nfull = 0;
        for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++) begin
                t_occ[r][c] = 1'b0;
                t_col[r][c] = '0;
            end
        for (int r = BOARD_H - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < BOARD_W; c++) if (!m_occ[r][c]) full = 1'b0;
            if (full) nfull++;
            else begin
                for (int c = 0; c < BOARD_W; c++) begin
                    t_occ[dst][c] = m_occ[r][c];
                    t_col[dst][c] = m_col[r][c];
                end
                dst--;
            end
        end
        m_occ = t_occ;
        m_col = t_col;
    endtask

    task automatic setup_board(input int code);
        for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++) begin
                p_occ[r][c] = 1'b0;
                p_col[r][c] = '0;
            end
        case (code)
            1: for (int c = 0; c < BOARD_W; c++) begin
                   if (c >= 4) begin p_occ[19][c] = 1'b1; p_col[19][c] = 3'd2; end
                   if (c % 2 == 0) begin p_occ[18][c] = 1'b1; p_col[18][c] = 3'd3; end
               end
            2: for (int r = 12; r < BOARD_H; r++)
                   for (int c = 0; c < BOARD_W; c++) begin
                       if (r >= 16 && c <= 8) begin p_occ[r][c] = 1'b1; p_col[r][c] = 3'((r % 7) + 1); end
                       if (r < 16 && c <= (r - 12) * 2) begin p_occ[r][c] = 1'b1; p_col[r][c] = 3'(r % 8); end
                   end
            3: for (int c = 0; c < BOARD_W; c++) begin
                   if (c >= 2) begin p_occ[19][c] = 1'b1; p_col[19][c] = 3'd1; end
                   if (c != 2 && c != 3) begin p_occ[17][c] = 1'b1; p_col[17][c] = 3'd6; end
                   if (c == 5) begin p_occ[18][c] = 1'b1; p_col[18][c] = 3'd7; end
                   if (c == 0) begin p_occ[16][c] = 1'b1; p_col[16][c] = 3'd2; end
               end
            9: for (int r = 10; r < BOARD_H; r++) begin
                   hole[r] = int'($urandom_range(0, BOARD_W - 1));
                   for (int c = 0; c < BOARD_W; c++)
                       if (c != hole[r]) begin p_occ[r][c] = 1'b1; p_col[r][c] = 3'($urandom_range(1, 7)); end
               end
            default: ;
        endcase
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic run_seq(input logic [3:0][5:0] xs, input logic [3:0][5:0] ys, input colour_t col,
                           input bit rep, input int tbl_lines, input string tag, output int vd_cyc);
        int cyc, vd_cnt, wd_cnt, wd_cyc, nfull, exp_lines, mism;
        logic [3:0] we_seen, we_exp;
        bit busy_bad;
        for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++) begin
                m_occ[r][c] = b_occ[r][c];
                m_col[r][c] = b_col[r][c];
            end
        we_exp = '0;
        for (int i = 0; i < 4; i++)
            if (int'(xs[i]) < BOARD_W && int'(ys[i]) < BOARD_H) begin
                m_occ[ys[i]][xs[i]] = 1'b1;
                m_col[ys[i]][xs[i]] = col;
                we_exp[i] = 1'b1;
            end
        model_compact(nfull);
        exp_lines = (nfull > 4) ? 4 : nfull;
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = exp_score + SCORE_TBL[exp_lines];
        if (exp_score > 24'hFFFFFF) exp_score = 24'hFFFFFF;
`else
        exp_score = 0;
`endif
        x0 = xs[0]; x1 = xs[1]; x2 = xs[2]; x3 = xs[3];
        y0 = ys[0]; y1 = ys[1]; y2 = ys[2]; y3 = ys[3];
        write_colour = col;
        validate_start = 1'b1;
        @(posedge clk); #1;
        validate_start = 1'b0;
        cyc = 1; vd_cnt = 0; vd_cyc = -1; wd_cnt = 0; wd_cyc = -1; we_seen = '0; busy_bad = 1'b0;
        while (cyc <= BUDGET && !(vd_cnt > 0 && cyc > vd_cyc + 20)) begin
            if (cyc <= 4) we_seen[cyc-1] = mem_we;
            if (write_done) begin wd_cnt++; wd_cyc = cyc; end
            if (validate_done) begin vd_cnt++; if (vd_cnt == 1) vd_cyc = cyc; end
            if (vd_cnt == 0 && !busy) busy_bad = 1'b1;
            if (rep && cyc == 3) begin validate_start = 1'b1; x0 = 6'd1; end
            else begin validate_start = 1'b0; x0 = xs[0]; end
            @(posedge clk); #1;
            cyc++;
        end
        mism = 0;
        for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++)
                if (b_occ[r][c] !== m_occ[r][c] || b_col[r][c] !== m_col[r][c]) mism++;
        chk({tag, "_we_pattern"}, we_seen, we_exp);
        chk({tag, "_write_done_cnt"}, wd_cnt, 1);
        chk({tag, "_write_done_cyc"}, wd_cyc, 5);
        chk({tag, "_validate_done_cnt"}, vd_cnt, 1);
        chk({tag, "_busy_while_active"}, busy_bad, 0);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_lines_model"}, lines_cleared, exp_lines);
        if (tbl_lines >= 0) chk({tag, "_lines_table"}, lines_cleared, tbl_lines);
        chk({tag, "_score"}, score, exp_score);
        chk({tag, "_board_mismatches"}, mism, 0);
    endtask

    typedef struct {
        int              code;
        logic [3:0][5:0] xs;
        logic [3:0][5:0] ys;
        colour_t         col;
        bit              rep;
        int              exp_lines;
    } vec_t;

    vec_t vt [5];

    initial begin
        int vd;
        int cyc;
        bit found;
        logic [3:0][5:0] rx, ry;

        vt[0] = '{0, {6'd6, 6'd5, 6'd4, 6'd3}, {4{6'd19}}, 3'd5, 1'b0, 0};
        vt[1] = '{1, {6'd3, 6'd2, 6'd1, 6'd0}, {4{6'd19}}, 3'd5, 1'b0, 1};
        vt[2] = '{2, {4{6'd9}}, {6'd19, 6'd18, 6'd17, 6'd16}, 3'd4, 1'b0, 4};
        vt[3] = '{3, {6'd3, 6'd2, 6'd1, 6'd0}, {6'd17, 6'd17, 6'd19, 6'd19}, 3'd3, 1'b0, 2};
        vt[4] = '{0, {6'd6, 6'd5, 6'd4, 6'd3}, {6'd19, 6'd20, 6'd19, 6'd19}, 3'd6, 1'b1, 0};

        rst = 1'b1; validate_start = 1'b0; write_colour = '0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0; y0 = '0; y1 = '0; y2 = '0; y3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_write_done", write_done, 0);
        chk("rst_validate_done", validate_done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_score", score, 0);
        chk("rst_addr", {mem_rd_x, mem_rd_y, mem_wr_x, mem_wr_y, mem_wr_occ, mem_wr_colour}, 0);
        rst = 1'b0;
        setup_board(0);

        for (int i = 0; i < 5; i++) begin
            setup_board(vt[i].code);
            run_seq(vt[i].xs, vt[i].ys, vt[i].col, vt[i].rep, vt[i].exp_lines, $sformatf("vec%0d", i), vd);
            if (i == 0) chk("vec0_done_latency", vd, 25);
        end

        // Reset while shifting rows down
        setup_board(1);
        x0 = 6'd0; x1 = 6'd1; x2 = 6'd2; x3 = 6'd3;
        y0 = 6'd19; y1 = 6'd19; y2 = 6'd19; y3 = 6'd19;
        write_colour = 3'd5;
        validate_start = 1'b1;
        @(posedge clk); #1;
        validate_start = 1'b0;
        cyc = 1; found = 1'b0;
        while (cyc < 400 && !found) begin
            if (cyc > 5 && mem_we) found = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        chk("rstmid_shift_reached", found, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_busy_before", busy, 1);
        chk("rstmid_lines_before", lines_cleared, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_mem_we", mem_we, 0);
        chk("rstmid_lines", lines_cleared, 0);
        chk("rstmid_score", score, 0);
        chk("rstmid_validate_done", validate_done, 0);
        rst = 1'b0;
        exp_score = 0;
        setup_board(0);
        run_seq(vt[0].xs, vt[0].ys, vt[0].col, 1'b0, 0, "after_rst", vd);

        // Random boards with one hole per bottom row; piece cells often plug holes
        for (int n = 0; n < 25; n++) begin
            setup_board(9);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int row;
                    row = int'($urandom_range(10, BOARD_H - 1));
                    rx[i] = 6'(hole[row]);
                    ry[i] = 6'(row);
                end else begin
                    rx[i] = 6'($urandom_range(0, BOARD_W + 1));
                    ry[i] = 6'($urandom_range(0, BOARD_H + 1));
                end
            end
            run_seq(rx, ry, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", n), vd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
